// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns the PC, IR and condition flags and steps
// each instruction through FETCH, DECODE and EXECUTE ahead of the decoder.
module fetch_sequencer #(
    parameter int unsigned          PC_WIDTH     = 10,
    parameter int unsigned          INSTR_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
    parameter int unsigned          RETIRE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imemReq,
    output logic [PC_WIDTH-1:0]     imemAddr,
    input  logic                    imemReady,
    input  logic [INSTR_WIDTH-1:0]  imemData,
    output logic [3:0]              opcode,
    output logic [11:0]             dataIn,
    output logic                    execValid,
    input  logic                    jump,
    input  logic                    neg,
    input  logic                    zero,
    input  logic                    constant,
    input  logic                    compare,
    input  logic                    aluEnable,
    input  logic                    halt,
    input  logic [PC_WIDTH-1:0]     dOut,
    input  logic [PC_WIDTH-1:0]     regTarget,
    input  logic                    aluNeg,
    input  logic                    aluZero,
    input  logic                    exBusy,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    flagN,
    output logic                    flagZ,
    output logic [RETIRE_WIDTH-1:0] retired,
    output logic                    halted
);

    typedef enum logic [1:0] {StFetch, StDecode, StExecute, StHalted} state_e;

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
    logic                    flag_n_q, flag_n_d;
    logic                    flag_z_q, flag_z_d;
    logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
    // Keeps the request low during reset and for the edge it is released on.
    logic                    req_en_q;

    logic                    taken;
    logic [PC_WIDTH-1:0]     target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            retired_q <= '0;
            req_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            flag_n_q  <= flag_n_d;
            flag_z_q  <= flag_z_d;
            retired_q <= retired_d;
            req_en_q  <= 1'b1;
        end
    end

    // Branch uses the flags as they stood before this instruction's compare.
    assign taken  = jump & ((~neg & ~zero) | (neg & flag_n_q) | (zero & flag_z_q));
    assign target = constant ? dOut : regTarget;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flag_n_d  = flag_n_q;
        flag_z_d  = flag_z_q;
        retired_d = retired_q;
        unique case (state_q)
            StFetch: begin
                if (req_en_q && imemReady) begin
                    ir_d    = imemData;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = StExecute;
            StExecute: begin
                if (!exBusy) begin
                    retired_d = retired_q + RETIRE_WIDTH'(1);
                    if (halt) begin
                        state_d = StHalted;
                    end else begin
                        if (compare && aluEnable) begin
                            flag_n_d = aluNeg;
                            flag_z_d = aluZero;
                        end
                        pc_d    = taken ? target : pc_q + PC_WIDTH'(1);
                        state_d = StFetch;
                    end
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
    end

    assign imemReq   = (state_q == StFetch) && req_en_q;
    assign imemAddr  = pc_q;
    assign execValid = (state_q == StExecute);
    assign halted    = (state_q == StHalted);
    assign opcode    = ir_q[15:12];
    assign dataIn    = ir_q[11:0];
    assign pc        = pc_q;
    assign flagN     = flag_n_q;
    assign flagZ     = flag_z_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against an architectural model
// (PC, flags, retire count, halt) updated once per completed instruction.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReq;
    logic [9:0]  imemAddr;
    logic        imemReady;
    logic [15:0] imemData;
    logic [3:0]  opcode;
    logic [11:0] dataIn;
    logic        execValid;
    logic        jump, neg, zero, constant, compare, aluEnable, halt;
    logic [9:0]  dOut, regTarget;
    logic        aluNeg, aluZero, exBusy;
    logic [9:0]  pc;
    logic        flagN, flagZ;
    logic [15:0] retired;
    logic        halted;

    typedef struct packed {
        logic       j, n, z, c, cmp, alu, h;
        logic [9:0] d, r;
        logic       an, az;
    } dec_t;

    int tests = 0;
    int fails = 0;

    // Architectural reference state
    logic [9:0]  m_pc;
    logic        m_fn, m_fz, m_halted;
    logic [15:0] m_ret;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
        .opcode(opcode), .dataIn(dataIn), .execValid(execValid),
        .jump(jump), .neg(neg), .zero(zero), .constant(constant), .compare(compare),
        .aluEnable(aluEnable), .halt(halt), .dOut(dOut), .regTarget(regTarget),
        .aluNeg(aluNeg), .aluZero(aluZero), .exBusy(exBusy),
        .pc(pc), .flagN(flagN), .flagZ(flagZ), .retired(retired), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic dec_t mk(input bit j, n, z, c, cmp, alu, h,
                                input logic [9:0] d, r, input bit an, az);
        dec_t x;
        x = '{j, n, z, c, cmp, alu, h, d, r, an, az};
        return x;
    endfunction

    task automatic drive_dec(input dec_t x);
        jump = x.j; neg = x.n; zero = x.z; constant = x.c; compare = x.cmp;
        aluEnable = x.alu; halt = x.h; dOut = x.d; regTarget = x.r;
        aluNeg = x.an; aluZero = x.az;
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".flags"}, {30'b0, flagN, flagZ}, {30'b0, m_fn, m_fz});
        chk({tag, ".retired"}, 32'(retired), 32'(m_ret));
        chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
    endtask

    // Spec rules for one completed instruction.
    task automatic model_retire(input dec_t x);
        bit tk;
        m_ret = m_ret + 16'd1;
        if (x.h) begin
            m_halted = 1'b1;
        end else begin
            tk = x.j && ((!x.n && !x.z) || (x.n && m_fn) || (x.z && m_fz));
            if (tk) m_pc = x.c ? x.d : x.r;
            else    m_pc = m_pc + 10'd1;
            if (x.cmp && x.alu) begin
                m_fn = x.an;
                m_fz = x.az;
            end
        end
    endtask

    // Called at a negedge with the DUT in FETCH; returns at a negedge after completion.
    task automatic do_instr(input logic [15:0] word, input int wait_cyc, input int busy_cyc,
                            input dec_t x);
        drive_dec(x);
        exBusy = 1'b0;
        for (int i = 0; i <= wait_cyc; i++) begin
            chk("fetch.req", 32'(imemReq), 32'd1);
            chk("fetch.addr", 32'(imemAddr), 32'(m_pc));
            chk("fetch.exv", 32'(execValid), 32'd0);
            if (i == wait_cyc) begin
                imemReady = 1'b1;
                imemData  = word;
            end else begin
                imemReady = 1'b0;
                imemData  = 16'($urandom);
            end
            @(negedge clk);
            if (i < wait_cyc) chk("fetch.pc_stable", 32'(pc), 32'(m_pc));
        end
        imemReady = 1'($urandom);
        imemData  = 16'($urandom);
        chk("decode.req", 32'(imemReq), 32'd0);
        chk("decode.exv", 32'(execValid), 32'd0);
        chk("decode.ir", {16'b0, opcode, dataIn}, {16'b0, word});
        for (int k = 0; k <= busy_cyc; k++) begin
            @(negedge clk);
            imemReady = 1'b0;
            chk("exec.exv", 32'(execValid), 32'd1);
            chk("exec.ir", {16'b0, opcode, dataIn}, {16'b0, word});
            chk_arch("exec");
            exBusy = (k < busy_cyc);
        end
        model_retire(x);
        @(negedge clk);
        exBusy = 1'b0;
        chk("post.exv", 32'(execValid), 32'd0);
        chk("post.req", 32'(imemReq), 32'(!m_halted));
        chk_arch("post");
    endtask

    initial begin
        dec_t nop, x;
        nop = mk(0, 0, 0, 0, 0, 1, 0, 10'h0, 10'h0, 0, 0);
        rst_n = 1'b0; imemReady = 1'b1; imemData = 16'hBEEF; exBusy = 1'b0;
        drive_dec(nop);
        m_pc = '0; m_fn = 0; m_fz = 0; m_ret = '0; m_halted = 0;

        // Reset state (imemReady high during reset must be ignored)
        repeat (2) @(negedge clk);
        chk("rst.req", 32'(imemReq), 32'd0);
        chk("rst.exv", 32'(execValid), 32'd0);
        chk("rst.ir", {20'b0, opcode, dataIn} & 32'hFFFF, 32'd0);
        chk_arch("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ir_after", {16'b0, opcode, dataIn}, 32'd0);

        // Add, immediate ready
        do_instr(16'h3123, 0, 0, nop);
        // Memory stalls 4 cycles
        do_instr(16'h3456, 4, 0, nop);
        // Compare neg, then jmpl taken
        do_instr(16'h6001, 0, 0, mk(0, 0, 0, 0, 1, 1, 0, 10'h0, 10'h0, 1, 0));
        do_instr(16'hA040, 1, 0, mk(1, 1, 0, 1, 1, 0, 0, 10'h040, 10'h155, 0, 1));
        chk("jmpl.taken", 32'(pc), 32'h040);
        // Compare non-neg, then jmpl not taken
        do_instr(16'h6002, 0, 0, mk(0, 0, 0, 0, 1, 1, 0, 10'h0, 10'h0, 0, 0));
        do_instr(16'hA040, 0, 0, mk(1, 1, 0, 1, 1, 0, 0, 10'h040, 10'h155, 1, 1));
        chk("jmpl.not_taken", 32'(pc), 32'h042);
        // Unconditional register jump with exBusy 2 cycles
        do_instr(16'hF000, 0, 2, mk(1, 0, 0, 0, 1, 0, 0, 10'h111, 10'h2AA, 1, 1));
        chk("jmp.reg", 32'(pc), 32'h2AA);
        // Jump to 0x3FF, then wrap
        do_instr(16'hF3FF, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 10'h3FF, 10'h0, 0, 0));
        do_instr(16'h3000, 2, 1, nop);
        chk("pc.wrap", 32'(pc), 32'h000);

        // Randomized instructions
        for (int n = 0; n < 60; n++) begin
            x = dec_t'({$urandom, $urandom});
            x.h = 1'b0;
            do_instr(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), x);
        end

        // Force known non-zero flags, then reset during a busy EXECUTE
        do_instr(16'h6003, 0, 0, mk(0, 0, 0, 0, 1, 1, 0, 10'h0, 10'h0, 1, 1));
        drive_dec(mk(1, 0, 0, 1, 1, 1, 0, 10'h0AB, 10'h0CD, 0, 0));
        imemReady = 1'b1; imemData = 16'hF0AB;
        @(negedge clk);
        imemReady = 1'b0; exBusy = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort.pre_exv", 32'(execValid), 32'd1);
        rst_n = 1'b0;
        #1;
        m_pc = '0; m_fn = 0; m_fz = 0; m_ret = '0; m_halted = 0;
        chk("abort.exv", 32'(execValid), 32'd0);
        chk("abort.req", 32'(imemReq), 32'd0);
        chk_arch("abort");
        exBusy = 1'b0; imemReady = 1'b1; imemData = 16'h7777;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.ready_ignored", {16'b0, opcode, dataIn}, 32'd0);
        chk("abort.fetch_req", 32'(imemReq), 32'd1);
        chk_arch("abort.fetch");
        do_instr(16'h3001, 0, 0, nop);

        // Halt and stay frozen
        do_instr(16'h0000, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 10'h3, 10'h3, 1, 1));
        for (int i = 0; i < 22; i++) begin
            imemReady = 1'($urandom); exBusy = 1'($urandom);
            drive_dec(dec_t'({$urandom, $urandom}));
            @(negedge clk);
            chk("halt.req", 32'(imemReq), 32'd0);
            chk("halt.exv", 32'(execValid), 32'd0);
            chk_arch("halt");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
